// File: rtl/sys_axi_b_arb.sv
// ============================================================================
// Module   : sys_axi_b_arb
// Purpose  : Round-robin merge of N_SRC AXI write-response channels onto one
//            registered upstream B channel, with source tag and error counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module sys_axi_b_arb #(
    parameter int N_SRC = 4,
    parameter int ID_W  = `AXI_ID_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC*ID_W-1:0]      s_bid,
    input  logic [N_SRC*2-1:0]         s_bresp,
    input  logic [N_SRC-1:0]           s_bvalid,
    output logic [N_SRC-1:0]           s_bready,
    output logic [ID_W-1:0]            m_bid,
    output logic [1:0]                 m_bresp,
    output logic                       m_bvalid,
    input  logic                       m_bready,
    output logic [$clog2(N_SRC)-1:0]   m_bsrc,
    output logic [15:0]                err_cnt,
    input  logic                       err_clr
);

    localparam int SRC_W = $clog2(N_SRC);
    localparam logic [15:0] c_err_max = 16'hFFFF;

    logic [SRC_W-1:0] r_ptr;
    logic [ID_W-1:0]  r_bid;
    logic [1:0]       r_bresp;
    logic             r_bvalid;
    logic [SRC_W-1:0] r_bsrc;
    logic [15:0]      r_err_cnt;

    logic             w_load_en;
    logic             w_found;
    logic [N_SRC-1:0] w_grant;
    logic [SRC_W-1:0] w_gidx;
    logic [ID_W-1:0]  w_sel_bid;
    logic [1:0]       w_sel_bresp;

    assign w_load_en = !r_bvalid || m_bready;

    // Two passes: indices above the pointer first, then wrap to 0..ptr.
    always_comb begin
        w_found     = 1'b0;
        w_grant     = '0;
        w_gidx      = '0;
        w_sel_bid   = '0;
        w_sel_bresp = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!w_found && s_bvalid[i] && (i > int'(r_ptr))) begin
                w_found     = 1'b1;
                w_grant[i]  = 1'b1;
                w_gidx      = SRC_W'(i);
                w_sel_bid   = s_bid[i*ID_W +: ID_W];
                w_sel_bresp = s_bresp[i*2 +: 2];
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (!w_found && s_bvalid[i] && (i <= int'(r_ptr))) begin
                w_found     = 1'b1;
                w_grant[i]  = 1'b1;
                w_gidx      = SRC_W'(i);
                w_sel_bid   = s_bid[i*ID_W +: ID_W];
                w_sel_bresp = s_bresp[i*2 +: 2];
            end
        end
    end

    // Ready depends combinationally on m_bready through w_load_en.
    assign s_bready = w_load_en ? w_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= SRC_W'(N_SRC - 1);
            r_bid    <= '0;
            r_bresp  <= '0;
            r_bvalid <= 1'b0;
            r_bsrc   <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_ptr    <= w_gidx;
                r_bid    <= w_sel_bid;
                r_bresp  <= w_sel_bresp;
                r_bsrc   <= w_gidx;
                r_bvalid <= 1'b1;
            end else begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (r_bvalid && m_bready && r_bresp[1] && (r_err_cnt != c_err_max)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign m_bid    = r_bid;
    assign m_bresp  = r_bresp;
    assign m_bvalid = r_bvalid;
    assign m_bsrc   = r_bsrc;
    assign err_cnt  = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sys_axi_b_arb.sv
// ============================================================================
// Module   : tb_sys_axi_b_arb
// Purpose  : Self-checking bench for sys_axi_b_arb: reference arbiter model
//            with a beat scoreboard, vector table and directed corner cases.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sys_axi_b_arb;

    localparam int N   = 4;
    localparam int IDW = 4;
    localparam int SW  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*IDW-1:0] s_bid;
    logic [N*2-1:0]   s_bresp;
    logic [N-1:0]     s_bvalid;
    logic [N-1:0]     s_bready;
    logic [IDW-1:0]   m_bid;
    logic [1:0]       m_bresp;
    logic             m_bvalid;
    logic             m_bready;
    logic [SW-1:0]    m_bsrc;
    logic [15:0]      err_cnt;
    logic             err_clr;

    always #5 clk = ~clk;

    sys_axi_b_arb #(.N_SRC(N), .ID_W(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_bid    (s_bid),
        .s_bresp  (s_bresp),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .m_bid    (m_bid),
        .m_bresp  (m_bresp),
        .m_bvalid (m_bvalid),
        .m_bready (m_bready),
        .m_bsrc   (m_bsrc),
        .err_cnt  (err_cnt),
        .err_clr  (err_clr)
    );

    typedef struct packed {
        logic [IDW-1:0] bid;
        logic [1:0]     bresp;
        logic [SW-1:0]  src;
    } beat_t;

    typedef struct {
        logic [N-1:0]   valid;
        logic [1:0]     bresp;
        logic [N-1:0]   exp_ready;
        logic           exp_mvalid;
        logic [SW-1:0]  exp_src;
        logic [IDW-1:0] exp_bid;
    } vec_t;

    beat_t       sb_q[$];
    int          mdl_ptr;
    logic [15:0] mdl_err;
    int          n_chk;
    int          n_fail;
    int          pulses[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbiter: modular scan from ptr+1.
    function automatic int mdl_grant(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx = (mdl_ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [1:0] r);
        s_bvalid = v;
        for (int i = 0; i < N; i++) begin
            s_bid[i*IDW +: IDW] = IDW'(i + 1);
            s_bresp[i*2 +: 2]   = r;
        end
    endtask

    task automatic mdl_reset();
        sb_q.delete();
        mdl_ptr = N - 1;
        mdl_err = '0;
    endtask

    // Entered just after a falling edge with inputs driven; returns at next falling edge.
    task automatic cycle();
        int   g;
        logic load;
        #1;
        load = (sb_q.size() == 0) || m_bready;
        g    = mdl_grant(s_bvalid);
        check("s_bready", 32'(s_bready), (load && g >= 0) ? (32'd1 << g) : 32'd0);
        check("m_bvalid", 32'(m_bvalid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check("m_bid",   32'(m_bid),   32'(sb_q[0].bid));
            check("m_bresp", 32'(m_bresp), 32'(sb_q[0].bresp));
            check("m_bsrc",  32'(m_bsrc),  32'(sb_q[0].src));
        end
        check("err_cnt", 32'(err_cnt), 32'(mdl_err));
        @(posedge clk);
        if (err_clr)
            mdl_err = '0;
        else if (sb_q.size() != 0 && m_bready && sb_q[0].bresp[1] && mdl_err != 16'hFFFF)
            mdl_err = mdl_err + 16'd1;
        if (sb_q.size() != 0 && m_bready) void'(sb_q.pop_front());
        if (load && g >= 0) begin
            sb_q.push_back('{s_bid[g*IDW +: IDW], s_bresp[g*2 +: 2], SW'(g)});
            mdl_ptr = g;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        drive('0, 2'b00);
        m_bready = 1'b0;
        err_clr  = 1'b0;
        mdl_reset();
        #1;
        check("rst_m_bvalid", 32'(m_bvalid), 32'd0);
        check("rst_m_bid",    32'(m_bid),    32'd0);
        check("rst_m_bresp",  32'(m_bresp),  32'd0);
        check("rst_m_bsrc",   32'(m_bsrc),   32'd0);
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
        check("rst_s_bready", 32'(s_bready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[5];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive('0, 2'b00);
        m_bready = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);

        // From reset the pointer is N-1, so the lowest valid index wins.
        tbl[0] = '{4'b0100, 2'b00, 4'b0100, 1'b1, 2'd2, 4'd3};
        tbl[1] = '{4'b1010, 2'b10, 4'b0010, 1'b1, 2'd1, 4'd2};
        tbl[2] = '{4'b1000, 2'b01, 4'b1000, 1'b1, 2'd3, 4'd4};
        tbl[3] = '{4'b0000, 2'b00, 4'b0000, 1'b0, 2'd0, 4'd0};
        tbl[4] = '{4'b1111, 2'b11, 4'b0001, 1'b1, 2'd0, 4'd1};

        for (int t = 0; t < 5; t++) begin
            do_reset();
            drive(tbl[t].valid, tbl[t].bresp);
            m_bready = 1'b1;
            #1;
            check("vec_s_bready", 32'(s_bready), 32'(tbl[t].exp_ready));
            cycle();
            drive('0, 2'b00);
            #1;
            check("vec_m_bvalid", 32'(m_bvalid), 32'(tbl[t].exp_mvalid));
            if (tbl[t].exp_mvalid) begin
                check("vec_m_bsrc", 32'(m_bsrc), 32'(tbl[t].exp_src));
                check("vec_m_bid",  32'(m_bid),  32'(tbl[t].exp_bid));
            end
            check("vec_err_cnt", 32'(err_cnt), 32'd0);
            cycle();
            cycle();
        end

        // Round-robin with all sources valid
        do_reset();
        for (int i = 0; i < N; i++) pulses[i] = 0;
        m_bready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) drive('1, 2'b00);
            else       drive('0, 2'b00);
            #1;
            if (c > 0) check("rr_m_bsrc", 32'(m_bsrc), 32'((c - 1) % N));
            for (int i = 0; i < N; i++) if (s_bready[i]) pulses[i]++;
            cycle();
        end
        for (int i = 0; i < N; i++) check("rr_pulses", 32'(pulses[i]), 32'd2);

        // Backpressure: hold a source-1 beat while sources 0 and 3 wait
        do_reset();
        m_bready = 1'b1;
        drive(4'b0010, 2'b00);
        cycle();
        m_bready = 1'b0;
        drive(4'b1001, 2'b00);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_s_bready", 32'(s_bready), 32'd0);
            check("bp_m_bvalid", 32'(m_bvalid), 32'd1);
            check("bp_m_bsrc",   32'(m_bsrc),   32'd1);
            check("bp_m_bid",    32'(m_bid),    32'd2);
            cycle();
        end
        m_bready = 1'b1;
        #1;
        check("bp_release_grant", 32'(s_bready), 32'b1000);
        cycle();
        drive('0, 2'b00);
        #1;
        check("bp_next_src", 32'(m_bsrc), 32'd3);
        repeat (3) cycle();

        // Error counting: SLVERR, DECERR, OKAY
        do_reset();
        m_bready = 1'b1;
        drive(4'b0001, 2'b10); cycle();
        drive(4'b0001, 2'b11); cycle();
        drive(4'b0001, 2'b00); cycle();
        drive('0, 2'b00);
        cycle();
        cycle();
        #1;
        check("err_cnt_two", 32'(err_cnt), 32'd2);

        // Drive the counter up to saturation with back-to-back SLVERR beats
        drive(4'b0001, 2'b10);
        repeat (65536) cycle();
        #1;
        check("err_cnt_sat", 32'(err_cnt), 32'hFFFF);
        cycle();
        #1;
        check("err_cnt_sat_hold", 32'(err_cnt), 32'hFFFF);

        // Clear coincident with an accepted SLVERR beat
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        drive('0, 2'b00);
        #1;
        check("err_clr_wins", 32'(err_cnt), 32'd0);
        repeat (3) cycle();

        // Asynchronous reset while a beat is stalled on the output
        do_reset();
        m_bready = 1'b1;
        drive(4'b0100, 2'b00);
        cycle();
        m_bready = 1'b0;
        drive('0, 2'b00);
        #1;
        check("mid_pre_bvalid", 32'(m_bvalid), 32'd1);
        #1;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check("mid_async_bvalid", 32'(m_bvalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_bready = 1'b1;
        drive('1, 2'b00);
        #1;
        check("mid_first_grant", 32'(s_bready), 32'b0001);
        cycle();

        // Sparse traffic: one beat from source 1, then idle
        drive(4'b0010, 2'b00);
        cycle();
        drive('0, 2'b00);
        cycle();
        for (int c = 0; c < 10; c++) begin
            #1;
            check("idle_m_bvalid", 32'(m_bvalid), 32'd0);
            check("idle_s_bready", 32'(s_bready), 32'd0);
            cycle();
        end
        drive('1, 2'b00);
        #1;
        check("idle_ptr_kept", 32'(s_bready), 32'b0100);
        cycle();
        drive('0, 2'b00);
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sys_axi_b_arb.md
Name: sys_axi_b_arb

Overview:
- Merges write-response (B) channels from N_SRC downstream slaves onto one upstream master-facing B channel.
- Uses round-robin arbitration with one registered output stage.
- Sits in the SoC interconnect between the slave-side B ports (AXI B master modport of each slave) and the CPU/DMA-side B port (slave modport of the requester).
- Also reports which source produced each response and keeps a saturating error-response counter for debug.

Parameters:
- N_SRC, 4, number of downstream B sources (2..8).
- ID_W, `AXI_ID_WIDTH, BID width.
- SRC_W, $clog2(N_SRC), source index width (derived, not overridable).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_bid  in  N_SRC*ID_W  per-source BID, source i at [i*ID_W +: ID_W].
- s_bresp  in  N_SRC*2  per-source BRESP, source i at [i*2 +: 2].
- s_bvalid  in  N_SRC  per-source BVALID.
- s_bready  out  N_SRC  per-source BREADY.
- m_bid  out  ID_W  merged BID.
- m_bresp  out  2  merged BRESP.
- m_bvalid  out  1  merged BVALID.
- m_bready  in  1  merged BREADY.
- m_bsrc  out  SRC_W  index of the source that produced the current m_b* beat.
- err_cnt  out  16  count of accepted responses with BRESP[1]=1 (SLVERR/DECERR).
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - m_bvalid=0, m_bid=0, m_bresp=0, m_bsrc=0, err_cnt=0, s_bready=0.
  - RR pointer=N_SRC-1, so source 0 has first priority.
- Output register (one entry):
  - load_en = !m_bvalid || m_bready.
  - On load_en with any grant: register takes the granted source's bid/bresp/index and sets m_bvalid=1.
  - On load_en with no grant: m_bvalid=0.
  - m_b* hold stable while m_bvalid && !m_bready (AXI rule).
- Arbitration (combinational):
  - Search s_bvalid starting at (ptr+1) mod N_SRC, wrapping; the first set bit wins. grant is one-hot or zero.
  - s_bready[i] = load_en && grant[i]. At most one s_bready is high per cycle, and s_bready never rises for a source with s_bvalid=0.
  - s_bready combinationally depends on m_bready; this path is documented and accepted.
  - The ptr register updates to the granted index only when a handshake occurs (s_bvalid[g] && s_bready[g]).
- Latency and throughput:
  - Latency is 1 cycle from source handshake to m_bvalid.
  - Back-to-back: when m_bready=1 continuously, one beat per cycle is sustained; a new beat loads in the same cycle the old one is accepted.
- Fairness: with all sources continuously valid, grants rotate 0,1,..,N_SRC-1,0; no source waits more than N_SRC-1 grants.
- Source stall: a source whose BVALID is held is never dropped; it is re-offered each cycle until granted.
- err_cnt:
  - Increments by 1 on m_bvalid && m_bready && m_bresp[1].
  - Saturates at 16'hFFFF.
  - err_clr=1 forces err_cnt=0 next cycle; clear wins over a simultaneous increment.
- Reset mid-operation: a pending output beat is discarded and m_bvalid drops immediately. Sources must also be reset by the same rst_n (system contract).
- No ID remapping: m_bid = source BID unchanged. Upstream routing uses m_bsrc.

Test Plan:
- Single source:
  - Stimulus: s_bvalid=4'b0100, bid=3, bresp=0, m_bready=1.
  - Required: s_bready[2]=1 in the same cycle; next cycle m_bvalid=1, m_bid=3, m_bsrc=2; err_cnt stays 0.
- Round-robin:
  - Stimulus: all 4 sources valid for 8 cycles, m_bready=1.
  - Required: m_bsrc sequence 0,1,2,3,0,1,2,3; each source receives exactly 2 s_bready pulses.
- Backpressure:
  - Stimulus: beat from source 1 loaded, then m_bready=0 for 5 cycles while sources 0 and 3 are valid.
  - Required: m_b* stable; s_bready=0 throughout; after m_bready=1 the next beat comes from source 3 (ptr was 1).
- Errors and saturation:
  - Stimulus: 3 accepted beats with bresp=2'b10, 2'b11, 2'b00.
  - Required: err_cnt=2.
  - Stimulus: preload to 16'hFFFF via forced sequence, then another SLVERR. Required: err_cnt stays FFFF.
  - Stimulus: err_clr coincident with an SLVERR accept. Required: err_cnt=0.
- Reset mid-beat:
  - Stimulus: rst_n low asynchronously while m_bvalid=1, m_bready=0.
  - Required: m_bvalid=0 immediately; after release the first grant goes to source 0 when all are valid.
- Sparse/zero traffic:
  - Stimulus: no s_bvalid for 10 cycles after a beat is accepted.
  - Required: m_bvalid=0; no s_bready asserted; ptr unchanged.
